// File: rtl/vend_ctrl_multi.sv
// -----------------------------------------------------------------------------
// vend_ctrl_multi
// Multi-product vending controller. Accumulates coin credit, checks a
// selection against a static per-product price vector, holds the dispenser
// enable for DISP_CYCLES cycles and then returns any remaining credit as a
// one-cycle change pulse. All outputs are registered.
//
// Optional feature (macro VEND_STOCK_EN):
//   adds per-product stock counters, a restock input and a sold_out vector.
//   With the macro undefined the build has no stock logic and products never
//   run out.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   coin_valid/coin_val coin strobe and coin value
//   sel_valid/sel_id    selection strobe and product index
//   cancel              refund request strobe
//   price_vec           static prices, product i at [i*PRICE_W +: PRICE_W]
//   credit              current credit
//   busy                high while dispensing or paying change
//   disp_en/disp_id     dispenser drive and product being dispensed
//   change_valid/amt    one-cycle change pulse and its value
//   coin_reject         one-cycle pulse, coin not accepted
//   short_funds         one-cycle pulse, selection refused (credit / stock)
//   bad_sel             one-cycle pulse, sel_id out of range
//   restock, sold_out   (VEND_STOCK_EN only) stock reload and per-product empty
// -----------------------------------------------------------------------------
module vend_ctrl_multi #(
    parameter int NUM_PROD    = 4,
    parameter int SEL_W       = $clog2(NUM_PROD),
    parameter int PRICE_W     = 8,
    parameter int CREDIT_W    = 8,
    parameter int DISP_CYCLES = 3
`ifdef VEND_STOCK_EN
    ,
    parameter int STOCK_W     = 4,
    parameter int STOCK_INIT  = 15
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         coin_valid,
    input  logic [PRICE_W-1:0]           coin_val,
    input  logic                         sel_valid,
    input  logic [SEL_W-1:0]             sel_id,
    input  logic                         cancel,
    input  logic [NUM_PROD*PRICE_W-1:0]  price_vec,
    output logic [CREDIT_W-1:0]          credit,
    output logic                         busy,
    output logic                         disp_en,
    output logic [SEL_W-1:0]             disp_id,
    output logic                         change_valid,
    output logic [CREDIT_W-1:0]          change_amt,
    output logic                         coin_reject,
    output logic                         short_funds,
    output logic                         bad_sel
`ifdef VEND_STOCK_EN
    ,
    input  logic                         restock,
    output logic [NUM_PROD-1:0]          sold_out
`endif
);

    // Arithmetic is done one bit wider than the widest operand so that coin
    // overflow and credit-vs-price comparisons never wrap.
    localparam int SUM_W = ((CREDIT_W > PRICE_W) ? CREDIT_W : PRICE_W) + 1;
    localparam logic [SUM_W-1:0] CREDIT_MAX = SUM_W'({CREDIT_W{1'b1}});
    localparam logic [SEL_W:0]   NUM_PROD_W = (SEL_W + 1)'(NUM_PROD);
    localparam int CNT_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DISP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CREDIT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                busy_q, busy_d;
    logic                disp_en_q, disp_en_d;
    logic [SEL_W-1:0]    disp_id_q, disp_id_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                change_valid_q, change_valid_d;
    logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
    logic                coin_reject_q, coin_reject_d;
    logic                short_funds_q, short_funds_d;
    logic                bad_sel_q, bad_sel_d;

    logic [PRICE_W-1:0]  price_s;
    logic [SUM_W-1:0]    coin_sum_s;
    logic                coin_ovf_s;
    logic                sel_bad_s;
    logic                credit_short_s;
    logic                sel_sold_s;

    // Price of the selected product; out-of-range indices yield zero (they are
    // rejected as bad_sel before the price is ever used).
    always_comb begin
        price_s = '0;
        for (int i = 0; i < NUM_PROD; i++) begin
            price_s = price_s | (({1'b0, sel_id} == (SEL_W + 1)'(i))
                                 ? price_vec[i*PRICE_W +: PRICE_W]
                                 : {PRICE_W{1'b0}});
        end
    end

    assign coin_sum_s     = SUM_W'(credit_q) + SUM_W'(coin_val);
    assign coin_ovf_s     = (coin_sum_s > CREDIT_MAX);
    assign sel_bad_s      = ({1'b0, sel_id} >= NUM_PROD_W);
    assign credit_short_s = (SUM_W'(credit_q) < SUM_W'(price_s));

`ifdef VEND_STOCK_EN
    localparam logic [STOCK_W-1:0] STOCK_INIT_V = STOCK_W'(STOCK_INIT);

    logic [STOCK_W-1:0]  stock_q [NUM_PROD];
    logic [STOCK_W-1:0]  stock_d [NUM_PROD];
    logic [NUM_PROD-1:0] sold_out_q, sold_out_d;
    logic                disp_entry_s;

    // Selected product has no stock left (checked before price).
    always_comb begin
        sel_sold_s = 1'b0;
        for (int i = 0; i < NUM_PROD; i++) begin
            sel_sold_s = sel_sold_s |
                         (({1'b0, sel_id} == (SEL_W + 1)'(i)) && (stock_q[i] == '0));
        end
    end

    assign disp_entry_s = (state_d == ST_DISPENSE) && (state_q != ST_DISPENSE);

    // Stock next-state: restock (only when idle/crediting) wins over the
    // decrement that accompanies entry into DISPENSE.
    always_comb begin
        for (int i = 0; i < NUM_PROD; i++) begin
            stock_d[i] = stock_q[i];
        end
        if (restock && !busy_q) begin
            for (int i = 0; i < NUM_PROD; i++) begin
                stock_d[i] = STOCK_INIT_V;
            end
        end else if (disp_entry_s) begin
            for (int i = 0; i < NUM_PROD; i++) begin
                stock_d[i] = (disp_id_d == SEL_W'(i)) ? (stock_q[i] - STOCK_W'(1))
                                                      : stock_q[i];
            end
        end else begin
            for (int i = 0; i < NUM_PROD; i++) begin
                stock_d[i] = stock_q[i];
            end
        end
        for (int i = 0; i < NUM_PROD; i++) begin
            sold_out_d[i] = (stock_d[i] == '0);
        end
    end

    // Stock counters and registered sold_out flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PROD; i++) begin
                stock_q[i] <= STOCK_INIT_V;
            end
            sold_out_q <= {NUM_PROD{(STOCK_INIT_V == '0)}};
        end else begin
            for (int i = 0; i < NUM_PROD; i++) begin
                stock_q[i] <= stock_d[i];
            end
            sold_out_q <= sold_out_d;
        end
    end

    assign sold_out = sold_out_q;
`else
    assign sel_sold_s = 1'b0;
`endif

    // Next-state and next-output logic. In IDLE/CREDIT the priority is
    // cancel > selection > coin; any coin arriving alongside a cancel or a
    // selection is rejected.
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        disp_en_d      = 1'b0;
        disp_id_d      = disp_id_q;
        cnt_d          = cnt_q;
        change_valid_d = 1'b0;
        change_amt_d   = '0;
        coin_reject_d  = 1'b0;
        short_funds_d  = 1'b0;
        bad_sel_d      = 1'b0;
        busy_d         = 1'b0;
        case (state_q)
            ST_IDLE, ST_CREDIT: begin
                if (cancel) begin
                    coin_reject_d = coin_valid;
                    if ((state_q == ST_CREDIT) && (credit_q != '0)) begin
                        state_d        = ST_CHANGE;
                        change_valid_d = 1'b1;
                        change_amt_d   = credit_q;
                        credit_d       = '0;
                    end else begin
                        state_d = state_q;
                    end
                end else if (sel_valid) begin
                    coin_reject_d = coin_valid;
                    if (sel_bad_s) begin
                        bad_sel_d = 1'b1;
                    end else if (sel_sold_s || credit_short_s) begin
                        short_funds_d = 1'b1;
                    end else begin
                        // disp_en rises at the same edge that enters DISPENSE,
                        // giving one cycle from selection to dispense.
                        state_d   = ST_DISPENSE;
                        disp_id_d = sel_id;
                        credit_d  = CREDIT_W'(SUM_W'(credit_q) - SUM_W'(price_s));
                        disp_en_d = 1'b1;
                        cnt_d     = '0;
                    end
                end else if (coin_valid) begin
                    if (coin_ovf_s) begin
                        coin_reject_d = 1'b1;
                    end else begin
                        credit_d = CREDIT_W'(coin_sum_s);
                        state_d  = ST_CREDIT;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DISPENSE: begin
                coin_reject_d = coin_valid;
                if (cnt_q == CNT_LAST) begin
                    if (credit_q != '0) begin
                        state_d        = ST_CHANGE;
                        change_valid_d = 1'b1;
                        change_amt_d   = credit_q;
                        credit_d       = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    disp_en_d = 1'b1;
                end
            end
            ST_CHANGE: begin
                coin_reject_d = coin_valid;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_DISPENSE) || (state_d == ST_CHANGE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            credit_q       <= '0;
            busy_q         <= 1'b0;
            disp_en_q      <= 1'b0;
            disp_id_q      <= '0;
            cnt_q          <= '0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
            coin_reject_q  <= 1'b0;
            short_funds_q  <= 1'b0;
            bad_sel_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            busy_q         <= busy_d;
            disp_en_q      <= disp_en_d;
            disp_id_q      <= disp_id_d;
            cnt_q          <= cnt_d;
            change_valid_q <= change_valid_d;
            change_amt_q   <= change_amt_d;
            coin_reject_q  <= coin_reject_d;
            short_funds_q  <= short_funds_d;
            bad_sel_q      <= bad_sel_d;
        end
    end

    assign credit       = credit_q;
    assign busy         = busy_q;
    assign disp_en      = disp_en_q;
    assign disp_id      = disp_id_q;
    assign change_valid = change_valid_q;
    assign change_amt   = change_amt_q;
    assign coin_reject  = coin_reject_q;
    assign short_funds  = short_funds_q;
    assign bad_sel      = bad_sel_q;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// -----------------------------------------------------------------------------
// tb_vend_ctrl_multi
// Self-checking bench for vend_ctrl_multi: a table of directed vectors with
// hand-derived expectations, a stock sequence (VEND_STOCK_EN builds only),
// then randomized traffic compared against a schedule-queue reference model.
// SEL_W is widened to 3 so out-of-range product indices can be driven.
// -----------------------------------------------------------------------------
module tb_vend_ctrl_multi;

    localparam int NP   = 4;
    localparam int SW   = 3;
    localparam int DC   = 3;
    localparam int CMAX = 255;
    localparam int SINIT = 1;
    localparam int PRICES [NP] = '{25, 50, 75, 100};

    logic          clk;
    logic          rst;
    logic          coin_valid;
    logic [7:0]    coin_val;
    logic          sel_valid;
    logic [SW-1:0] sel_id;
    logic          cancel;
    logic [31:0]   price_vec;
    logic [7:0]    credit;
    logic          busy;
    logic          disp_en;
    logic [SW-1:0] disp_id;
    logic          change_valid;
    logic [7:0]    change_amt;
    logic          coin_reject;
    logic          short_funds;
    logic          bad_sel;
`ifdef VEND_STOCK_EN
    logic          restock;
    logic [NP-1:0] sold_out;
`endif

    int checks = 0;
    int errors = 0;

    vend_ctrl_multi #(
        .NUM_PROD(NP), .SEL_W(SW), .PRICE_W(8), .CREDIT_W(8), .DISP_CYCLES(DC)
`ifdef VEND_STOCK_EN
        , .STOCK_W(4), .STOCK_INIT(SINIT)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .coin_valid(coin_valid), .coin_val(coin_val),
        .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel),
        .price_vec(price_vec),
        .credit(credit), .busy(busy), .disp_en(disp_en), .disp_id(disp_id),
        .change_valid(change_valid), .change_amt(change_amt),
        .coin_reject(coin_reject), .short_funds(short_funds), .bad_sel(bad_sel)
`ifdef VEND_STOCK_EN
        , .restock(restock), .sold_out(sold_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Each accepted vend or refund is turned into a schedule of future output
    // cycles; while the schedule plays out the machine is busy.
    typedef struct {
        bit den;
        bit chv;
        int cred;
        int amt;
    } slot_t;

    slot_t sched[$];
    int    m_credit, m_did, m_amt;
    bit    m_busy, m_den, m_chv, m_crej, m_sf, m_bs;
    int    m_stock [NP];

    function automatic bit [NP-1:0] m_sold();
        bit [NP-1:0] r;
        for (int i = 0; i < NP; i++) r[i] = (m_stock[i] == 0);
        return r;
    endfunction

    task automatic play_next();
        slot_t s;
        s = sched.pop_front();
        m_busy   = 1'b1;
        m_den    = s.den;
        m_chv    = s.chv;
        m_amt    = s.amt;
        m_credit = s.cred;
    endtask

    task automatic model_step(input bit rs);
        int  price, rem, idx;
        bit  sold;
        slot_t s;
        m_crej = 1'b0; m_sf = 1'b0; m_bs = 1'b0; m_chv = 1'b0; m_amt = 0;
        if (rst) begin
            sched.delete();
            m_credit = 0; m_busy = 1'b0; m_den = 1'b0; m_did = 0;
            for (int i = 0; i < NP; i++) m_stock[i] = SINIT;
        end else if (m_busy) begin
            m_crej = coin_valid;
            if (sched.size() > 0) play_next();
            else begin m_busy = 1'b0; m_den = 1'b0; end
        end else begin
            idx = int'(sel_id);
            if (cancel) begin
                m_crej = coin_valid;
                if (m_credit > 0) begin
                    s.den = 1'b0; s.chv = 1'b1; s.cred = 0; s.amt = m_credit;
                    sched.push_back(s);
                    play_next();
                end
            end else if (sel_valid) begin
                m_crej = coin_valid;
                if (idx >= NP) m_bs = 1'b1;
                else begin
                    price = PRICES[idx];
`ifdef VEND_STOCK_EN
                    sold = (m_stock[idx] == 0);
`else
                    sold = 1'b0;
`endif
                    if (sold || m_credit < price) m_sf = 1'b1;
                    else begin
                        rem   = m_credit - price;
                        m_did = idx;
                        for (int k = 0; k < DC; k++) begin
                            s.den = 1'b1; s.chv = 1'b0; s.cred = rem; s.amt = 0;
                            sched.push_back(s);
                        end
                        if (rem > 0) begin
                            s.den = 1'b0; s.chv = 1'b1; s.cred = 0; s.amt = rem;
                            sched.push_back(s);
                        end
                        m_stock[idx] = m_stock[idx] - 1;
                        play_next();
                    end
                end
            end else if (coin_valid) begin
                if (m_credit + int'(coin_val) > CMAX) m_crej = 1'b1;
                else m_credit = m_credit + int'(coin_val);
            end
            if (rs) begin
                for (int i = 0; i < NP; i++) m_stock[i] = SINIT;
            end
        end
    endtask

    // ---------------- drive / check helpers ----------------
    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d actual=%0d required=%0d", name, idx, act, exp);
        end
    endtask

    // One clock: drive inputs, clock edge, step the model, settle.
    task automatic cyc(input bit r, input bit cv, input int cval, input bit sv,
                       input int sid, input bit can, input bit rs);
        rst        = r;
        coin_valid = cv;
        coin_val   = 8'(cval);
        sel_valid  = sv;
        sel_id     = SW'(sid);
        cancel     = can;
`ifdef VEND_STOCK_EN
        restock    = rs;
`endif
        @(posedge clk);
        model_step(rs);
        #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit r; bit cv; int cval; bit sv; int sid; bit can;
        int e_cred; bit e_busy; bit e_den; int e_did; bit e_chv; int e_amt;
        bit e_crej; bit e_sf; bit e_bs;
    } vec_t;

    vec_t tbl[$];

    task automatic v(input bit r, input bit cv, input int cval, input bit sv,
                     input int sid, input bit can,
                     input int ec, input bit eb, input bit ed, input int eid,
                     input bit ech, input int ea, input bit ecr, input bit esf,
                     input bit ebs);
        vec_t t;
        t.r = r; t.cv = cv; t.cval = cval; t.sv = sv; t.sid = sid; t.can = can;
        t.e_cred = ec; t.e_busy = eb; t.e_den = ed; t.e_did = eid; t.e_chv = ech;
        t.e_amt = ea; t.e_crej = ecr; t.e_sf = esf; t.e_bs = ebs;
        tbl.push_back(t);
    endtask

    int cv_pool [9] = '{0, 1, 5, 10, 25, 50, 100, 200, 255};

    initial begin
        rst = 1'b1; coin_valid = 1'b0; coin_val = 8'd0; sel_valid = 1'b0;
        sel_id = '0; cancel = 1'b0;
        price_vec = {8'd100, 8'd75, 8'd50, 8'd25};
`ifdef VEND_STOCK_EN
        restock = 1'b0;
`endif
        //  r cv val sv id can | cred busy den did chv amt crej sf bs
        v(1,0,  0,0,0,0,   0,0,0,0,0,  0,0,0,0);   // reset
        // exact-price purchase, no change
        v(0,1, 25,0,0,0,  25,0,0,0,0,  0,0,0,0);
        v(0,1, 25,0,0,0,  50,0,0,0,0,  0,0,0,0);
        v(0,1, 25,0,0,0,  75,0,0,0,0,  0,0,0,0);
        v(0,0,  0,1,2,0,   0,1,1,2,0,  0,0,0,0);
        v(0,0,  0,0,0,0,   0,1,1,2,0,  0,0,0,0);
        v(0,1, 25,1,1,1,   0,1,1,2,0,  0,1,0,0);   // inputs while dispensing
        v(0,0,  0,0,0,0,   0,0,0,2,0,  0,0,0,0);
        v(0,0,  0,0,0,1,   0,0,0,2,0,  0,0,0,0);   // cancel at zero credit
        // purchase with change
        v(0,1,100,0,0,0, 100,0,0,2,0,  0,0,0,0);
        v(0,0,  0,1,0,0,  75,1,1,0,0,  0,0,0,0);
        v(0,0,  0,0,0,0,  75,1,1,0,0,  0,0,0,0);
        v(0,0,  0,0,0,0,  75,1,1,0,0,  0,0,0,0);
        v(0,0,  0,0,0,0,   0,1,0,0,1, 75,0,0,0);
        v(0,0,  0,0,0,0,   0,0,0,0,0,  0,0,0,0);
        // short funds then refund
        v(0,1, 25,0,0,0,  25,0,0,0,0,  0,0,0,0);
        v(0,0,  0,1,3,0,  25,0,0,0,0,  0,0,1,0);
        v(0,0,  0,0,0,1,   0,1,0,0,1, 25,0,0,0);
        v(0,0,  0,0,0,0,   0,0,0,0,0,  0,0,0,0);
        // credit ceiling and coin + selection collision
        v(0,1,100,0,0,0, 100,0,0,0,0,  0,0,0,0);
        v(0,1,100,0,0,0, 200,0,0,0,0,  0,0,0,0);
        v(0,1, 50,0,0,0, 250,0,0,0,0,  0,0,0,0);
        v(0,1, 10,0,0,0, 250,0,0,0,0,  0,1,0,0);
        v(0,1,  5,0,0,0, 255,0,0,0,0,  0,0,0,0);
        v(0,1,  1,0,0,0, 255,0,0,0,0,  0,1,0,0);
        v(0,1,  0,0,0,0, 255,0,0,0,0,  0,0,0,0);
        v(0,1, 10,1,1,0, 205,1,1,1,0,  0,1,0,0);
        v(0,0,  0,0,0,0, 205,1,1,1,0,  0,0,0,0);
        v(0,0,  0,0,0,0, 205,1,1,1,0,  0,0,0,0);
        v(0,0,  0,0,0,0,   0,1,0,1,1,205,0,0,0);
        v(0,0,  0,0,0,0,   0,0,0,1,0,  0,0,0,0);
        v(0,0,  0,1,0,0,   0,0,0,1,0,  0,0,1,0);   // zero credit selection
        // reset in the second dispense cycle discards credit
        v(1,0,  0,0,0,0,   0,0,0,0,0,  0,0,0,0);
        v(0,1,100,0,0,0, 100,0,0,0,0,  0,0,0,0);
        v(0,0,  0,1,0,0,  75,1,1,0,0,  0,0,0,0);
        v(0,0,  0,0,0,0,  75,1,1,0,0,  0,0,0,0);
        v(1,0,  0,0,0,0,   0,0,0,0,0,  0,0,0,0);
        v(0,0,  0,0,0,0,   0,0,0,0,0,  0,0,0,0);
        // out-of-range selections
        v(0,0,  0,1,5,0,   0,0,0,0,0,  0,0,0,1);
        v(0,0,  0,1,4,0,   0,0,0,0,0,  0,0,0,1);
        // cancel beats selection and coin
        v(0,1, 25,0,0,0,  25,0,0,0,0,  0,0,0,0);
        v(0,1, 25,1,0,1,   0,1,0,0,1, 25,1,0,0);
        v(0,0,  0,0,0,0,   0,0,0,0,0,  0,0,0,0);
        // zero coin accepted, cancel at zero credit ignored
        v(0,1,  0,0,0,0,   0,0,0,0,0,  0,0,0,0);
        v(0,0,  0,0,0,1,   0,0,0,0,0,  0,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].r, tbl[i].cv, tbl[i].cval, tbl[i].sv, tbl[i].sid, tbl[i].can, 1'b0);
            chk("tbl_credit",  i, 32'(credit),       32'(tbl[i].e_cred));
            chk("tbl_busy",    i, 32'(busy),         32'(tbl[i].e_busy));
            chk("tbl_disp_en", i, 32'(disp_en),      32'(tbl[i].e_den));
            chk("tbl_disp_id", i, 32'(disp_id),      32'(tbl[i].e_did));
            chk("tbl_chg_vld", i, 32'(change_valid), 32'(tbl[i].e_chv));
            if (tbl[i].e_chv) chk("tbl_chg_amt", i, 32'(change_amt), 32'(tbl[i].e_amt));
            chk("tbl_coin_rej", i, 32'(coin_reject), 32'(tbl[i].e_crej));
            chk("tbl_short",   i, 32'(short_funds),  32'(tbl[i].e_sf));
            chk("tbl_bad_sel", i, 32'(bad_sel),      32'(tbl[i].e_bs));
        end

`ifdef VEND_STOCK_EN
        // single-unit stock: second purchase of product 1 is refused
        cyc(1,0,0,0,0,0,0);  chk("stk_reset_sold", 0, 32'(sold_out), 32'd0);
        cyc(0,1,50,0,0,0,0);
        cyc(0,0,0,1,1,0,0);  chk("stk_vend_den", 1, 32'(disp_en), 32'd1);
                             chk("stk_sold_1",   1, 32'(sold_out), 32'b0010);
        cyc(0,0,0,0,0,0,1);  // restock while busy is ignored
        cyc(0,0,0,0,0,0,0);
        cyc(0,0,0,0,0,0,0);  chk("stk_busy_rs", 2, 32'(sold_out), 32'b0010);
        cyc(0,1,50,0,0,0,0);
        cyc(0,0,0,1,1,0,0);  chk("stk_short",   3, 32'(short_funds), 32'd1);
                             chk("stk_credit",  3, 32'(credit), 32'd50);
                             chk("stk_no_disp", 3, 32'(disp_en), 32'd0);
        cyc(0,0,0,0,0,1,0);  chk("stk_refund_v", 4, 32'(change_valid), 32'd1);
                             chk("stk_refund_a", 4, 32'(change_amt), 32'd50);
        cyc(0,0,0,0,0,0,0);
        cyc(0,0,0,0,0,0,1);  chk("stk_restock", 5, 32'(sold_out), 32'd0);
`endif

        // randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            bit r, cv, sv, can, rs;
            int cval, sid;
            r    = ($urandom_range(0, 199) == 0);
            cv   = ($urandom_range(0, 99) < 40);
            cval = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                               : cv_pool[$urandom_range(0, 8)];
            sv   = ($urandom_range(0, 99) < 15);
            sid  = int'($urandom_range(0, 7));
            can  = ($urandom_range(0, 99) < 5);
            rs   = ($urandom_range(0, 99) < 3);
            cyc(r, cv, cval, sv, sid, can, rs);
            chk("rnd_credit",  n, 32'(credit),       32'(m_credit));
            chk("rnd_busy",    n, 32'(busy),         32'(m_busy));
            chk("rnd_disp_en", n, 32'(disp_en),      32'(m_den));
            chk("rnd_disp_id", n, 32'(disp_id),      32'(m_did));
            chk("rnd_chg_vld", n, 32'(change_valid), 32'(m_chv));
            if (m_chv) chk("rnd_chg_amt", n, 32'(change_amt), 32'(m_amt));
            chk("rnd_coin_rej", n, 32'(coin_reject), 32'(m_crej));
            chk("rnd_short",   n, 32'(short_funds),  32'(m_sf));
            chk("rnd_bad_sel", n, 32'(bad_sel),      32'(m_bs));
`ifdef VEND_STOCK_EN
            chk("rnd_sold_out", n, 32'(sold_out), 32'(m_sold()));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_ctrl_multi.md
Name: vend_ctrl_multi

Overview:
Parametrised multi-product vending controller. It accumulates coin credit, checks each selection against a per-product price vector, and holds the dispenser enable for a fixed number of cycles. It then returns any remaining credit as change. It sits between the coin acceptor / keypad front-end and the dispenser actuators.

Parameters:
NUM_PROD, 4, number of selectable products (>=2)
SEL_W, $clog2(NUM_PROD), width of the product index
PRICE_W, 8, width of each price entry and of a coin value
CREDIT_W, 8, width of the credit accumulator
DISP_CYCLES, 3, cycles disp_en is held per vend (>=1)
STOCK_W, 4, stock counter width (only with VEND_STOCK_EN)
STOCK_INIT, 15, stock value loaded at reset or restock (only with VEND_STOCK_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
coin_valid  in  1  one-cycle strobe, coin inserted
coin_val  in  PRICE_W  value of the inserted coin
sel_valid  in  1  one-cycle strobe, product selected
sel_id  in  SEL_W  selected product index
cancel  in  1  one-cycle strobe, refund request
price_vec  in  NUM_PROD*PRICE_W  product i price at bits [i*PRICE_W +: PRICE_W]; static
credit  out  CREDIT_W  current credit
busy  out  1  high in DISPENSE and CHANGE
disp_en  out  1  dispenser drive
disp_id  out  SEL_W  product being dispensed
change_valid  out  1  one-cycle change pulse
change_amt  out  CREDIT_W  change value, valid with change_valid
coin_reject  out  1  one-cycle pulse, coin not accepted
short_funds  out  1  one-cycle pulse, credit below price
bad_sel  out  1  one-cycle pulse, sel_id >= NUM_PROD

Behaviour:
- States: IDLE, CREDIT, DISPENSE, CHANGE. All outputs are registered.
- Reset: state IDLE. credit, disp_en, disp_id, change_amt, busy and all pulses are 0.
- Reset has priority over every input in every state. Mid-vend reset drops disp_en at that edge and discards credit.
- Same-cycle priority in IDLE/CREDIT: cancel > sel_valid > coin_valid. A coin arriving with cancel or sel_valid is rejected (coin_reject=1, credit unchanged).
- Coin in IDLE/CREDIT: credit += coin_val, then go to CREDIT.
  - If the sum exceeds 2^CREDIT_W-1, the coin is rejected and credit is unchanged.
  - coin_val=0 is accepted as a no-op.
- Selection in IDLE/CREDIT:
  - sel_id >= NUM_PROD: bad_sel pulse, no state change.
  - credit < price: short_funds pulse, stay.
  - credit >= price (equality counts): latch disp_id, credit -= price, go to DISPENSE.
- Cancel in CREDIT with credit > 0: go to CHANGE. Cancel in IDLE or with credit 0: ignored.
- DISPENSE:
  - disp_en high for exactly DISP_CYCLES cycles, starting the cycle after entry; disp_id is held.
  - coin_valid gets coin_reject; sel_valid and cancel are ignored.
  - Exit: to CHANGE if credit > 0, else to IDLE.
- CHANGE: for one cycle, change_valid=1 and change_amt=credit; credit clears to 0; next state IDLE. Inputs are treated as in DISPENSE.
- Latency: accepted selection to first disp_en = 1 cycle.

Optional Feature:
Macro VEND_STOCK_EN.
- Defined: adds restock (in, 1) and sold_out (out, NUM_PROD).
  - Per-product STOCK_W counters load STOCK_INIT at reset or on restock (restock is ignored while busy).
  - A counter decrements on DISPENSE entry; sold_out[i] = (stock[i]==0).
  - Selecting a sold-out product gives a short_funds pulse, leaves credit unchanged, and does not dispense. Sold-out is checked before price.
- Undefined: no stock logic or ports; products never run out.

Test Plan:
(All with NUM_PROD=4, prices {25,50,75,100}, DISP_CYCLES=3.)
1. Coins 25,25,25, then sel_id=2 -> credit 75 -> 0; disp_en high 3 cycles with disp_id=2; no change_valid; return to IDLE.
2. Coin 100, sel_id=0 -> dispense id 0 for 3 cycles, then change_valid with change_amt=75, credit 0.
3. Coin 25, sel_id=3 -> short_funds pulse, credit stays 25; then cancel -> change_amt=25.
4. Credit 250, coin 10 -> coin_reject, credit 250. Coin and sel_valid in the same cycle -> coin rejected, selection evaluated.
5. rst asserted in the 2nd disp_en cycle -> disp_en=0, credit=0, state IDLE next cycle. sel_id=5 (width permitting) -> bad_sel pulse.
6. VEND_STOCK_EN, STOCK_INIT=1: buy product 1 twice with 50 each -> second attempt gives short_funds, sold_out[1]=1; cancel refunds 50; restock clears sold_out[1].
